uart_rx_core: RTL
=================

# uart_rx_core

Byte-level UART receiver for the PL timestamp/UART stage. It samples the asynchronous serial line at a fixed integer clocks-per-bit rate and recovers 8N1 frames. It emits one single-cycle `rx_valid` strobe with the data byte per good frame, directly feeding the record packer's `uart_rx_valid`/`uart_rx_data` inputs. Framing errors are flagged separately and never produce a data strobe.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 8.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_pin`  in  1  asynchronous serial line, idle high.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` holds a good byte.
- `rx_data`  out  8  received byte, LSB first on wire; held stable until the next strobe.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `rx_busy`  out  1  high in any state other than IDLE.

## Operation
- Input path: 2-flop synchronizer on `rx_pin` gives `rx_s`. The sync flops reset to 1. All decisions use `rx_s`.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide and clears on every state transition. `HALF = CLKS_PER_BIT/2` (integer division).
- Shift register `sh[7:0]` shifts right, with the new bit entering at bit 7. Bit index `bidx` runs 0..7.
- States:
  - **IDLE**: when `rx_s==0`, go to START.
  - **START**: at `cnt==HALF-1`, sample the line. If 0, go to DATA. If 1, treat as a glitch and go to IDLE with no strobe.
  - **DATA**: at `cnt==CLKS_PER_BIT-1`, sample into `sh`. After `bidx==7`, go to STOP; otherwise increment `bidx`.
  - **STOP**: at `cnt==CLKS_PER_BIT-1`, sample the line. If 1, load `rx_data<=sh`, pulse `rx_valid`, and go to IDLE. If 0, pulse `frame_err`, leave `rx_data` unchanged, and go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_s==1`, then go to IDLE. This prevents a held break from generating repeated errors.
- `rx_valid` and `frame_err` are never high in the same cycle, and never high for 2 consecutive cycles.
- No backpressure. The consumer must accept every strobe.

## Timing
- Reset values:
  - outputs: `rx_valid=0`, `frame_err=0`, `rx_data=8'h00`, `rx_busy=0`
  - internal: state=IDLE, `cnt=0`, `bidx=0`, `sh=0`, sync flops=1
- Reset applied mid-frame aborts the frame with no strobe. The block resumes in IDLE and needs a fresh falling edge.
- Pin-to-sync latency is 2 cycles.
- If S is the first cycle IDLE sees `rx_s==0`:
  - start sample at cycle S+HALF
  - data bit k sampled at S+HALF+(k+1)·CLKS_PER_BIT
  - stop sample at S+HALF+9·CLKS_PER_BIT
  - `rx_valid`/`frame_err` registered high in the following cycle
- Back-to-back frames: a start bit beginning immediately after the stop bit is accepted. IDLE is re-entered about HALF cycles before the stop bit ends.
- `rx_busy` rises the cycle after S and falls the cycle the strobe asserts. In the frame-error case it stays high through WAIT_HIGH.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - every sample (start, data, stop) is the 2-of-3 majority of `rx_s` at `cnt` = limit-2, limit-1 and limit, evaluated at limit.
  - a single glitched cycle near mid-bit is rejected.
- Undefined: single sample of `rx_s` at `cnt`=limit.
- Sample cycles and latency are identical in both builds.

## Test plan
All scenarios use `CLKS_PER_BIT=16`.
- **Basic frame.** Send byte 0xA5 as 8N1 after reset. Expect exactly one `rx_valid` with `rx_data=0xA5` at S+8+144+1, `frame_err` never high, and `rx_busy` low afterward.
- **Back-to-back.** Send 0x00, 0xFF, 0x5A with no idle gap. Expect 3 strobes in order with matching data and no `frame_err`.
- **Glitch start.** Drive `rx_pin` low for 4 cycles, then high. Expect no strobe, state back in IDLE, and `rx_busy` low within 12 cycles. A following 0x3C frame must still be received correctly.
- **Framing error / break.** Send 0x81 with the stop bit low, then hold the line low for 40 bit times. Expect one `frame_err` pulse, no `rx_valid`, and `rx_data` still holding the previous byte. After the line returns high, 0x42 must be received correctly.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 3 of 0xC3. Expect all outputs at reset values and no strobe for the aborted frame. The next frame, 0x11, must be received correctly.
- **Majority build** (`UART_RX_MAJORITY_EN`). Send 0xF0 with a 1-cycle inverted glitch at `cnt`=15 of bit 2. Expect `rx_data=0xF0`. Without the macro, the same stimulus yields 0xF4.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a fixed integer clocks-per-bit rate and a 2-flop input synchronizer.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of the last three synced samples.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LIM = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_LIM = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          syncA_q, syncB_q;
  logic          rxS;
  logic          sampleBit;

  // Sync flops reset high so a reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncA_q <= 1'b1;
      syncB_q <= 1'b1;
    end else begin
      syncA_q <= rx_pin;
      syncB_q <= syncA_q;
    end
  end

  assign rxS = syncB_q;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // hist_q[1] is rxS two cycles ago, hist_q[0] one cycle ago; the vote lands on the usual sample cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxS};
    end
  end

  assign sampleBit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxS) | (hist_q[0] & rxS);
`else
  assign sampleBit = rxS;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bidx_d = 3'd0;
        if (!rxS) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LIM) begin
          cnt_d   = '0;
          bidx_d  = 3'd0;
          state_d = sampleBit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LIM) begin
          cnt_d   = '0;
          shift_d = {sampleBit, shift_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LIM) begin
          cnt_d = '0;
          if (sampleBit) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held break must release the line before another frame can start.
        cnt_d = '0;
        if (rxS) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_valid  = valid_q;
  assign rx_data   = data_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule
